// File: rtl/sdram_write_master.sv
// Streams a frame of 24-bit pixels, one group at a time, to Avalon-MM memory. Writes are back-to-back and stall on master_waitrequest.
// Define WRITE_RESP_EN to wait for master_writeresponsevalid after each accepted write.
module sdram_write_master #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int GROUP      = 6
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic        group_ready,
  input  logic [23:0] pixel_in,
  input  logic        master_waitrequest,
  input  logic        master_writeresponsevalid,
  output logic        master_write,
  output logic [31:0] master_address,
  output logic [31:0] master_writedata,
  output logic [3:0]  master_byteenable,
  output logic        group_done,
  output logic        frame_done,
  output logic        busy
);

  localparam int TOTAL = IMG_WIDTH * IMG_HEIGHT;
  localparam int PCW   = $clog2(TOTAL) + 1;
  localparam int GCW   = $clog2(GROUP) + 1;

`ifdef WRITE_RESP_EN
  // Counters have already advanced when the response arrives, so compare against the end counts.
  localparam logic [PCW-1:0] PIX_END = PCW'(TOTAL);
  localparam logic [GCW-1:0] GRP_END = GCW'(GROUP);
`else
  localparam logic [PCW-1:0] PIX_LAST = PCW'(TOTAL - 1);
  localparam logic [GCW-1:0] GRP_LAST = GCW'(GROUP - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_GROUP,
    S_WRITE,
`ifdef WRITE_RESP_EN
    S_RESP,
`endif
    S_FRAME_DONE
  } state_t;

  state_t          r_state;
  logic [31:0]     r_addr;
  logic [PCW-1:0]  r_pix_cnt;
  logic [GCW-1:0]  r_grp_cnt;
  logic            w_accept;

  assign w_accept = (r_state == S_WRITE) && !master_waitrequest;

`ifdef WRITE_RESP_EN
  assign group_done = (r_state == S_RESP) && master_writeresponsevalid && (r_grp_cnt == GRP_END);
`else
  logic w_unused_resp;
  assign w_unused_resp = master_writeresponsevalid;
  assign group_done = w_accept && (r_grp_cnt == GRP_LAST);
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_pix_cnt <= '0;
      r_grp_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_addr    <= base_addr;
            r_pix_cnt <= '0;
            r_grp_cnt <= '0;
            r_state   <= S_WAIT_GROUP;
          end
        end
        S_WAIT_GROUP: begin
          if (group_ready) begin
            r_grp_cnt <= '0;
            r_state   <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (w_accept) begin
            r_addr    <= r_addr + 32'd4;
            r_pix_cnt <= r_pix_cnt + 1'b1;
            r_grp_cnt <= r_grp_cnt + 1'b1;
`ifdef WRITE_RESP_EN
            r_state   <= S_RESP;
`else
            if (r_grp_cnt == GRP_LAST)
              r_state <= (r_pix_cnt == PIX_LAST) ? S_FRAME_DONE : S_WAIT_GROUP;
`endif
          end
        end
`ifdef WRITE_RESP_EN
        S_RESP: begin
          if (master_writeresponsevalid) begin
            if (r_grp_cnt == GRP_END)
              r_state <= (r_pix_cnt == PIX_END) ? S_FRAME_DONE : S_WAIT_GROUP;
            else
              r_state <= S_WRITE;
          end
        end
`endif
        S_FRAME_DONE: r_state <= S_IDLE;
        default:      r_state <= S_IDLE;
      endcase
    end
  end

  assign master_write      = (r_state == S_WRITE);
  assign master_address    = r_addr;
  assign master_writedata  = {8'h00, pixel_in};
  assign master_byteenable = 4'b0111;
  assign frame_done        = (r_state == S_FRAME_DONE);
  assign busy              = (r_state != S_IDLE);

endmodule

// File: tb/tb_sdram_write_master.sv
// Directed bench for sdram_write_master on a 6x2 frame with 6-pixel groups.
module tb_sdram_write_master;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic        group_ready = 1'b0;
  logic [23:0] pixel_in = '0;
  logic        master_waitrequest = 1'b0;
  logic        master_writeresponsevalid = 1'b0;
  logic        master_write;
  logic [31:0] master_address;
  logic [31:0] master_writedata;
  logic [3:0]  master_byteenable;
  logic        group_done;
  logic        frame_done;
  logic        busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sdram_write_master #(.IMG_WIDTH(6), .IMG_HEIGHT(2), .GROUP(6)) dut (
    .clk                       (clk),
    .n_rst                     (n_rst),
    .start                     (start),
    .base_addr                 (base_addr),
    .group_ready               (group_ready),
    .pixel_in                  (pixel_in),
    .master_waitrequest        (master_waitrequest),
    .master_writeresponsevalid (master_writeresponsevalid),
    .master_write              (master_write),
    .master_address            (master_address),
    .master_writedata          (master_writedata),
    .master_byteenable         (master_byteenable),
    .group_done                (group_done),
    .frame_done                (frame_done),
    .busy                      (busy)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One pixel from request to completion; expects the DUT to be in WRITE on entry.
  task automatic px(input logic [31:0] a, input logic gd);
    logic [23:0] pix;
    pix = a[23:0] ^ 24'h5A5A5A;
    pixel_in = pix;
    #1;
    chk("write_req", {31'd0, master_write}, 32'd1);
    chk("write_addr", master_address, a);
    chk("write_data", master_writedata, {8'h00, pix});
`ifdef WRITE_RESP_EN
    chk("gdone_on_accept", {31'd0, group_done}, 32'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("resp_wait_nowrite", {31'd0, master_write}, 32'd0);
      chk("resp_wait_busy", {31'd0, busy}, 32'd1);
      tick();
    end
    master_writeresponsevalid = 1'b1;
    #1;
    chk("resp_gdone", {31'd0, group_done}, {31'd0, gd});
    chk("resp_nowrite", {31'd0, master_write}, 32'd0);
    tick();
    master_writeresponsevalid = 1'b0;
`else
    chk("gdone", {31'd0, group_done}, {31'd0, gd});
    tick();
`endif
  endtask

  // Start a frame, hold group_ready low for two cycles, then release into WRITE.
  task automatic frame_start(input logic [31:0] base);
    group_ready = 1'b0;
    start = 1'b1;
    base_addr = base;
    tick();
    start = 1'b0;
    base_addr = 32'hDEAD_BEEF;
    chk("wait_busy", {31'd0, busy}, 32'd1);
    chk("wait_nowrite", {31'd0, master_write}, 32'd0);
    tick();
    chk("wait_hold", {31'd0, master_write}, 32'd0);
    group_ready = 1'b1;
    tick();
  endtask

  task automatic run_frame(input logic [31:0] base);
    frame_start(base);
    for (int k = 0; k < 6; k++)
      px(base + 32'(4 * k), k == 5);
    chk("between_groups_nowrite", {31'd0, master_write}, 32'd0);
    chk("between_groups_busy", {31'd0, busy}, 32'd1);
    chk("between_groups_nofd", {31'd0, frame_done}, 32'd0);
    tick();
    for (int k = 0; k < 6; k++) begin
      start = (k == 2);
      px(base + 32'(24 + 4 * k), k == 5);
      start = 1'b0;
    end
    chk("frame_done_pulse", {31'd0, frame_done}, 32'd1);
    chk("frame_done_busy", {31'd0, busy}, 32'd1);
    chk("frame_done_nowrite", {31'd0, master_write}, 32'd0);
    tick();
    chk("after_frame_fd", {31'd0, frame_done}, 32'd0);
    chk("after_frame_busy", {31'd0, busy}, 32'd0);
    tick();
    chk("idle_nowrite", {31'd0, master_write}, 32'd0);
  endtask

  initial begin
    group_ready = 1'b1;
    repeat (2) tick();
    chk("rst_write", {31'd0, master_write}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_addr", master_address, 32'd0);
    chk("rst_gdone", {31'd0, group_done}, 32'd0);
    chk("rst_fdone", {31'd0, frame_done}, 32'd0);
    chk("byteenable", {28'd0, master_byteenable}, 32'h7);
    n_rst = 1'b1;
    repeat (2) tick();
    chk("no_write_without_start", {31'd0, master_write}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    run_frame(32'h1000_0000);

    // Stall the second write for three cycles, then reset during the third.
    frame_start(32'h2000_0000);
    px(32'h2000_0000, 1'b0);
    pixel_in = 24'hABCDEF;
    master_waitrequest = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) master_waitrequest = 1'b0;
      #1;
      chk("stall_write", {31'd0, master_write}, 32'd1);
      chk("stall_addr", master_address, 32'h2000_0004);
      chk("stall_data", master_writedata, 32'h00AB_CDEF);
      tick();
    end
`ifdef WRITE_RESP_EN
    master_writeresponsevalid = 1'b1;
    tick();
    master_writeresponsevalid = 1'b0;
`endif
    chk("third_write", {31'd0, master_write}, 32'd1);
    chk("third_addr", master_address, 32'h2000_0008);
    n_rst = 1'b0;
    #1;
    chk("rst_mid_write", {31'd0, master_write}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_addr", master_address, 32'd0);
    chk("rst_mid_gdone", {31'd0, group_done}, 32'd0);
    tick();
    n_rst = 1'b1;
    group_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("post_rst_nowrite", {31'd0, master_write}, 32'd0);
      chk("post_rst_idle", {31'd0, busy}, 32'd0);
      tick();
    end

    run_frame(32'hFFFF_FFF8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
